// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: takes a byte stream with a 16-bit little-endian word-count header
// and writes the payload into IM. The CPU is held in reset until the load completes.
module imem_stream_loader #(
    parameter int MEMORY_SIZE = 4096,
    parameter int MEMORY_BITS = 12,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    output logic                   in_ready,
    output logic                   im_we,
    output logic [MEMORY_BITS-1:0] im_addr,
    output logic [31:0]            im_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            words_loaded
);
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;
    localparam int IW = $clog2(TIMEOUT + 2);

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [23:0]            word_q, word_d;
    logic [MEMORY_BITS-1:0] word_idx_q, word_idx_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic                   in_ready_q, in_ready_d;
    logic                   im_we_q, im_we_d;
    logic [MEMORY_BITS-1:0] im_addr_q, im_addr_d;
    logic [31:0]            im_wdata_q, im_wdata_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            words_loaded_q, words_loaded_d;

    logic        accept;
    logic        timed_out;
    logic [15:0] hdr;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        word_idx_d     = word_idx_q;
        idle_d         = idle_q;
        in_ready_d     = in_ready_q;
        im_we_d        = 1'b0;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
        hdr            = {in_byte, cnt_q[7:0]};

        // Idle counter only matters while the header is half-received or payload is streaming.
        if (accept)
            idle_d = '0;
        else if (state_q == HDR_HI || state_q == DATA)
            idle_d = idle_q + 1'b1;
        timed_out = (TIMEOUT != 0) && !accept && (state_q == HDR_HI || state_q == DATA)
                    && (idle_q == IW'(TIMEOUT - 1));

        case (state_q)
            HDR_LO: begin
                if (accept) begin
                    cnt_d[7:0] = in_byte;
                    state_d    = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    cnt_d[15:8] = in_byte;
                    if (hdr == 16'd0)
                        state_d = DONE;
                    else if ({16'd0, hdr} > 32'(MEMORY_SIZE))
                        state_d = ERR;
                    else
                        state_d = DATA;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (words_loaded_q == cnt_q) begin
                    state_d = DONE;
                end else if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = in_byte;
                        2'd1: word_d[15:8]  = in_byte;
                        2'd2: word_d[23:16] = in_byte;
                        default: begin
                            im_we_d        = 1'b1;
                            im_addr_d      = word_idx_q;
                            im_wdata_d     = {in_byte, word_q};
                            word_idx_d     = word_idx_q + 1'b1;
                            words_loaded_d = words_loaded_q + 16'd1;
                            // Last word: stop taking bytes during its write pulse.
                            if (words_loaded_q + 16'd1 == cnt_q)
                                in_ready_d = 1'b0;
                        end
                    endcase
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            default: ;
        endcase

        if (state_d == DONE && state_q != DONE) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
            in_ready_d = 1'b0;
        end
        if (state_d == ERR) begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
            in_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HDR_LO;
            cnt_q          <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            word_idx_q     <= '0;
            idle_q         <= '0;
            in_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            word_idx_q     <= word_idx_d;
            idle_q         <= idle_d;
            in_ready_q     <= (state_q == HDR_LO) ? 1'b1 : in_ready_d;
            im_we_q        <= im_we_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: cycle-exact vector table plus hand sequences
// for throttled streaming, timeout and mid-load reset.
module tb_imem_stream_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, im_we, cpu_hold, done, err;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] words_loaded;

    imem_stream_loader #(.MEMORY_SIZE(4096), .MEMORY_BITS(12), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r, v;
        logic [7:0]  b;
        logic [64:0] exp;   // {ready, we, addr, wdata, hold, done, err, words}
    } vec_t;

    int n_pass = 0, n_total = 0;
    logic [43:0] wr_q[$];

    function automatic logic [64:0] pk(logic rdy, logic we, logic [11:0] a, logic [31:0] w,
                                       logic h, logic d, logic e, logic [15:0] wl);
        return {rdy, we, a, w, h, d, e, wl};
    endfunction

    function automatic vec_t mk(string n, logic r, logic v, logic [7:0] b, logic [64:0] e);
        vec_t t;
        t.name = n; t.r = r; t.v = v; t.b = b; t.exp = e;
        return t;
    endfunction

    function automatic logic [64:0] obs();
        return pk(in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, words_loaded);
    endfunction

    task automatic apply(input logic r, input logic v, input logic [7:0] b);
        rst = r; in_valid = v; in_byte = b;
        @(posedge clk);
        #1;
        if (im_we) wr_q.push_back({im_addr, im_wdata});
    endtask

    task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
        else n_pass++;
    endtask

    task automatic send(input logic [7:0] b);
        apply(1'b0, 1'b1, b);
    endtask

    localparam logic [64:0] RST_O = {1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0};
    localparam logic [64:0] FIN_O = {1'b0, 1'b0, 12'd1, 32'h00100093, 1'b0, 1'b1, 1'b0, 16'd2};
    logic [7:0] prog [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        vec_t tbl[$];
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;

        // Two-word program, valid held high
        tbl.push_back(mk("t1_reset",   1, 0, 8'h00, RST_O));
        tbl.push_back(mk("t1_release", 0, 0, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_hdr_lo",  0, 1, 8'h02, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_hdr_hi",  0, 1, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_b0",      0, 1, 8'h13, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_b1",      0, 1, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_b2",      0, 1, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t1_wr0",     0, 1, 8'h00, pk(1, 1, 0, 32'h00000013, 1, 0, 0, 1)));
        tbl.push_back(mk("t1_b4",      0, 1, 8'h93, pk(1, 0, 0, 32'h00000013, 1, 0, 0, 1)));
        tbl.push_back(mk("t1_b5",      0, 1, 8'h00, pk(1, 0, 0, 32'h00000013, 1, 0, 0, 1)));
        tbl.push_back(mk("t1_b6",      0, 1, 8'h10, pk(1, 0, 0, 32'h00000013, 1, 0, 0, 1)));
        tbl.push_back(mk("t1_wr1",     0, 1, 8'h00, pk(0, 1, 1, 32'h00100093, 1, 0, 0, 2)));
        tbl.push_back(mk("t1_done",    0, 0, 8'h00, FIN_O));
        tbl.push_back(mk("t1_extra",   0, 1, 8'h55, FIN_O));
        // Zero-length program
        tbl.push_back(mk("t2_reset",   1, 1, 8'h00, RST_O));
        tbl.push_back(mk("t2_release", 0, 0, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t2_hdr_lo",  0, 1, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t2_done",    0, 1, 8'h00, pk(0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk("t2_extra",   0, 1, 8'h13, pk(0, 0, 0, 0, 0, 1, 0, 0)));
        // Oversize header 0x1001
        tbl.push_back(mk("t3_reset",   1, 0, 8'h00, RST_O));
        tbl.push_back(mk("t3_release", 0, 0, 8'h00, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t3_hdr_lo",  0, 1, 8'h01, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mk("t3_err",     0, 1, 8'h10, pk(0, 0, 0, 0, 1, 0, 1, 0)));
        tbl.push_back(mk("t3_extra",   0, 1, 8'h00, pk(0, 0, 0, 0, 1, 0, 1, 0)));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].b);
            chk(tbl[i].name, obs(), tbl[i].exp);
        end

        // Throttled stream: valid every third cycle
        apply(1, 0, 8'h00);
        apply(0, 0, 8'h00);
        wr_q.delete();
        for (int i = 0; i < 10; i++) begin
            send(prog[i]);
            apply(0, 0, 8'h00);
            apply(0, 0, 8'h00);
        end
        chk("t4_nwrites", 65'(wr_q.size()), 65'd2);
        if (wr_q.size() == 2) begin
            chk("t4_wr0", 65'(wr_q[0]), 65'({12'd0, 32'h00000013}));
            chk("t4_wr1", 65'(wr_q[1]), 65'({12'd1, 32'h00100093}));
        end
        chk("t4_final", obs(), FIN_O);

        // Timeout: err exactly 16 cycles after the last accepted byte
        apply(1, 0, 8'h00);
        apply(0, 0, 8'h00);
        wr_q.delete();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        begin
            int early = 0;
            for (int k = 1; k <= 16; k++) begin
                apply(0, 0, 8'h00);
                if (k < 16 && err) early++;
            end
            chk("t5_no_early_err", 65'(early), 65'd0);
        end
        chk("t5_err", obs(), pk(0, 0, 0, 0, 1, 0, 1, 0));
        chk("t5_no_writes", 65'(wr_q.size()), 65'd0);

        // Reset right after the first word is written, then restream
        apply(1, 0, 8'h00);
        apply(0, 0, 8'h00);
        for (int i = 0; i < 6; i++) send(prog[i]);
        chk("t6_wr0_pulse", obs(), pk(1, 1, 0, 32'h00000013, 1, 0, 0, 1));
        apply(1, 1, 8'h93);
        chk("t6_reset", obs(), RST_O);
        apply(0, 0, 8'h00);
        chk("t6_ready", obs(), pk(1, 0, 0, 0, 1, 0, 0, 0));
        wr_q.delete();
        for (int i = 0; i < 10; i++) send(prog[i]);
        apply(0, 0, 8'h00);
        chk("t6_final", obs(), FIN_O);
        chk("t6_nwrites", 65'(wr_q.size()), 65'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
